// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one memory request at a time
// over req/gnt/rvalid, and queues returned words for decode in a small FIFO.
// A redirect flushes the FIFO and restarts fetching at a new PC; a response
// still in flight when the redirect arrives is dropped.
// Optional feature macro: FETCH_HALT_EN adds a 'halted' output. Fetching stops
// after an all-ones instruction is queued and resumes on the next redirect.
module instr_fetch_unit #(
    parameter int unsigned     PC_W       = 8,
    parameter int unsigned     INSTR_W    = 21,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
`ifdef FETCH_HALT_EN
    output logic               halted,
`endif
    input  logic               id_ready
);

    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    entry_t           fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic             halt_q, halt_d;

    // A word is queued only when it answers the live request; a redirect in
    // the same cycle discards it.
    assign push      = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = id_valid && id_ready;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign id_valid  = (count_q != '0);
    assign id_instr  = fifo_q[rd_ptr_q].instr;
    assign id_pc     = fifo_q[rd_ptr_q].pc;

`ifdef FETCH_HALT_EN
    // Halt latches on queuing an all-ones word; any redirect releases it.
    always_comb begin
        halt_d = halt_q;
        if (redirect_valid) begin
            halt_d = 1'b0;
        end else if (push && (&imem_rdata)) begin
            halt_d = 1'b1;
        end
    end

    // Halt flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign halted = halt_q;
`else
    assign halt_q = 1'b0;
    assign halt_d = 1'b0;
`endif

    // FIFO pointer and occupancy update; a redirect empties the queue.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Fetch FSM next state and PC; a redirect overrides the normal flow.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            IDLE: if (!halt_q && (count_q < DEPTH_C)) state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = ((count_d < DEPTH_C) && !halt_d) ? REQ : IDLE;
                end
            end
            DROP:    if (imem_rvalid) state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
            // A request accepted but not yet answered must have its response
            // swallowed before a new request may go out.
            if (((state_q == WAIT) && !imem_rvalid) ||
                ((state_q == REQ) && imem_gnt) ||
                ((state_q == DROP) && !imem_rvalid)) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: each entry carries the word and the PC it was fetched from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset because the head drives id_instr/id_pc,
            // which must read zero out of reset.
            fifo_q <= '{default: '0};
        end else if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder with adjustable latency,
// a sequence-level model (expected request address and expected next PC for
// decode) checked every cycle, and directed scenarios with literal values.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [7:0] RESET_PC = 8'h00;
    localparam logic [20:0] STRAY   = 21'h15A5A;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt       = 1'b0;
    logic        imem_rvalid    = 1'b0;
    logic [20:0] imem_rdata     = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc    = '0;
    logic        id_valid;
    logic [20:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_ready       = 1'b0;
`ifdef FETCH_HALT_EN
    logic        halted;
`endif

    instr_fetch_unit #(
        .PC_W(8), .INSTR_W(21), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
`ifdef FETCH_HALT_EN
        .halted(halted),
`endif
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Instruction memory contents.
    logic [20:0] imem [256];
    logic [20:0] exp_t1 [4] = '{21'h0A001, 21'h04005, 21'h1B0E0, 21'h08010};

    // Responder state.
    int         lat = 1;
    logic       pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] pend_addr = '0;

    // Model state and pop log.
    logic [7:0]  m_addr = RESET_PC;
    logic [7:0]  m_pc   = RESET_PC;
    int          n_grants = 0;
    int          n_pops = 0;
    logic [20:0] pop_instr [$];
    logic [7:0]  pop_pc [$];
    logic        prev_stall = 1'b0;
    logic [20:0] prev_instr = '0;
    logic [7:0]  prev_pc = '0;

    // Compare process: requests must walk addresses from the last redirect,
    // delivered words must walk PCs from the last redirect with memory data,
    // and a stalled head must not move.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            m_addr     = RESET_PC;
            m_pc       = RESET_PC;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", id_valid, 1'b1);
                check("stall_instr", id_instr, prev_instr);
                check("stall_pc", id_pc, prev_pc);
            end
            if (imem_req && imem_gnt) begin
                check("req_addr", imem_addr, m_addr);
                m_addr++;
                n_grants++;
            end
            if (id_valid && id_ready) begin
                check("id_pc", id_pc, m_pc);
                check("id_instr", id_instr, imem[m_pc]);
                pop_instr.push_back(id_instr);
                pop_pc.push_back(id_pc);
                m_pc++;
                n_pops++;
            end
            prev_stall = id_valid && !id_ready && !redirect_valid;
            prev_instr = id_instr;
            prev_pc    = id_pc;
            if (redirect_valid) begin
                m_addr = redirect_pc;
                m_pc   = redirect_pc;
            end
        end
    end

    // One cycle of stimulus: decode/redirect inputs plus the memory responder.
    task automatic tick_r(input logic rdy, input logic redir, input logic [7:0] rpc);
        @(negedge clk);
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = imem[pend_addr];
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (imem_req) begin
            imem_gnt  = 1'b1;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = lat;
        end
    endtask

    task automatic tick(input logic rdy);
        tick_r(rdy, 1'b0, 8'h00);
    endtask

    task automatic clear_log();
        pop_instr.delete();
        pop_pc.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_addr"}, imem_addr, RESET_PC);
        check({tag, "_valid"}, id_valid, 1'b0);
        check({tag, "_instr"}, id_instr, 21'h0);
        check({tag, "_pc"}, id_pc, 8'h00);
`ifdef FETCH_HALT_EN
        check({tag, "_halted"}, halted, 1'b0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        pend           = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_pops(input int target, input int budget, input string name);
        int start;
        int cyc;
        start = n_pops;
        cyc   = 0;
        while ((n_pops - start < target) && (cyc < budget)) begin
            tick(1'b1);
            #3;
            cyc++;
        end
        if (n_pops - start < target) check({name, "_timeout"}, n_pops - start, target);
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] pc, input logic [20:0] instr);
        if (idx < pop_pc.size()) begin
            check({name, "_pc"}, pop_pc[idx], pc);
            check({name, "_instr"}, pop_instr[idx], instr);
        end else begin
            check({name, "_missing"}, pop_pc.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int cyc;
        for (int i = 0; i < 256; i++) imem[i] = 21'((i << 9) ^ (i * 3 + 1));
        imem[0] = 21'h0A001;
        imem[1] = 21'h04005;
        imem[2] = 21'h1B0E0;
        imem[3] = 21'h08010;

        // Reset asserted: outputs at reset values.
        #1 rst_n = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Streaming fetch with decode always ready.
        clear_log();
        lat = 1;
        run_until_pops(4, 40, "t1");
        for (int i = 0; i < 4; i++) check_log("t1", i, 8'(i), exp_t1[i]);

        // Decode stalled from reset release: two words, then requests stop.
        do_reset();
        clear_log();
        g0 = n_grants;
        repeat (10) begin
            tick(1'b0);
            #3;
        end
        check("t2_grants", n_grants - g0, 2);
        check("t2_req_off", imem_req, 1'b0);
        check("t2_valid", id_valid, 1'b1);
        check("t2_head", id_instr, 21'h0A001);
        check("t2_head_pc", id_pc, 8'h00);
        run_until_pops(3, 40, "t2");
        check_log("t2_third", 2, 8'h02, 21'h1B0E0);

        // Redirect while waiting on the response for address 5.
        do_reset();
        lat = 3;
        cyc = 0;
        while (!(imem_gnt && imem_addr == 8'h05) && cyc < 80) begin
            tick(1'b1);
            cyc++;
        end
        check("t3_reach_addr5", imem_gnt && imem_addr == 8'h05, 1'b1);
        tick_r(1'b1, 1'b1, 8'h40);
        #3 clear_log();
        tick(1'b1);
        #3 check("t3_flushed", id_valid, 1'b0);
        run_until_pops(2, 60, "t3");
        check_log("t3_first", 0, 8'h40, 21'h080C1);

        // PC wrap: redirect to FE and fetch across the top of the space.
        lat = 1;
        tick_r(1'b1, 1'b1, 8'hFE);
        #3 clear_log();
        run_until_pops(4, 60, "t4");
        check_log("t4_w0", 0, 8'hFE, 21'h1FEFB);
        check_log("t4_w1", 1, 8'hFF, 21'h1FCFE);
        check_log("t4_w2", 2, 8'h00, 21'h0A001);
        check_log("t4_w3", 3, 8'h01, 21'h04005);

        // Reset in the middle of WAIT, then a stray response.
        lat = 3;
        cyc = 0;
        tick(1'b1);
        while (!imem_gnt && cyc < 20) begin
            tick(1'b1);
            cyc++;
        end
        check("t5_got_gnt", imem_gnt, 1'b1);
        tick(1'b1);
        rst_n       = 1'b0;
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        #1 check_reset_values("t5_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = STRAY;
        id_ready    = 1'b1;
        #3 clear_log();
        lat = 1;
        run_until_pops(2, 40, "t5");
        check_log("t5_first", 0, RESET_PC, 21'h0A001);
        check_log("t5_second", 1, 8'h01, 21'h04005);

`ifdef FETCH_HALT_EN
        // All-ones word halts fetching until a redirect.
        imem[3] = 21'h1FFFFF;
        do_reset();
        clear_log();
        g0 = n_grants;
        run_until_pops(4, 40, "t6");
        repeat (8) begin
            tick(1'b1);
            #3;
        end
        check_log("t6_halt_word", 3, 8'h03, 21'h1FFFFF);
        check("t6_halted", halted, 1'b1);
        check("t6_grants", n_grants - g0, 4);
        check("t6_req_off", imem_req, 1'b0);
        tick_r(1'b1, 1'b1, 8'h10);
        #3 clear_log();
        tick(1'b1);
        #3 check("t6_unhalted", halted, 1'b0);
        run_until_pops(1, 40, "t6r");
        check_log("t6_resume", 0, 8'h10, 21'h02031);
`endif

        repeat (2) tick(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
